// File: rtl/hci_streamer_job_sequencer_pkg.sv
// rtl/hci_streamer_job_sequencer_pkg.sv - streamer control/status types and sequencer states
package hci_streamer_job_sequencer_pkg;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] tot_len;
    logic [15:0] d0_stride;
  } ctrl_addressgen_v3_t;

  typedef struct packed {
    logic                req_start;
    ctrl_addressgen_v3_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } hci_streamer_flags_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT
  } hci_seq_state_t;

endpackage

// File: rtl/hci_job_fifo.sv
// rtl/hci_job_fifo.sv - job queue with fall-through head and registered full/empty
module hci_job_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push_ok;
  logic          pop_ok;

  // A full queue refuses pushes even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_o  <= (count_d == (AW+1)'(DEPTH));
      empty_o <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/hci_streamer_job_sequencer.sv
// rtl/hci_streamer_job_sequencer.sv - issues queued address-generator jobs to an HCI streamer
module hci_streamer_job_sequencer
  import hci_streamer_job_sequencer_pkg::*;
#(
  parameter int unsigned JOB_DEPTH   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  ctrl_addressgen_v3_t job_i,
  output hci_streamer_ctrl_t  ctrl_o,
  input  hci_streamer_flags_t flags_i,
  output logic                busy_o,
  output logic                job_done_o,
  output logic [CNT_W-1:0]    done_cnt_o,
  output logic                err_timeout_o
);

  localparam int unsigned QW      = $clog2(JOB_DEPTH) + 1;
  localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  hci_seq_state_t      state, state_d;
  ctrl_addressgen_v3_t head;
  logic                full, empty;
  logic [QW-1:0]       fifo_count;
  logic                push_acc, pop;
  logic                done_hit, timeout_hit;
  logic [WD_W-1:0]     wd_cnt;

  hci_job_fifo #(
    .T     (ctrl_addressgen_v3_t),
    .DEPTH (JOB_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (job_valid_i),
    .data_i  (job_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign job_ready_o = ~full;
  assign push_acc    = job_valid_i & ~full;
  assign busy_o      = ~empty | (state != SEQ_IDLE);

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      SEQ_IDLE:  if (!empty) state_d = SEQ_ISSUE;
      SEQ_ISSUE: if (flags_i.ready_start) state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        // done beats a watchdog expiry landing in the same cycle
        done_hit    = flags_i.done;
        timeout_hit = !flags_i.done && (TIMEOUT_CYC != 0) && (wd_cnt == WD_W'(WD_LAST));
        pop         = done_hit | timeout_hit;
        if (pop) state_d = (fifo_count > QW'(1) || push_acc) ? SEQ_ISSUE : SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.req_start = (state == SEQ_ISSUE);
    if (state != SEQ_IDLE) ctrl_o.addressgen_ctrl = head;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= SEQ_IDLE;
      wd_cnt        <= '0;
      job_done_o    <= 1'b0;
      done_cnt_o    <= '0;
      err_timeout_o <= 1'b0;
    end else if (clear_i) begin
      state         <= SEQ_IDLE;
      wd_cnt        <= '0;
      job_done_o    <= 1'b0;
      done_cnt_o    <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state      <= state_d;
      job_done_o <= done_hit;
      if (done_hit) done_cnt_o <= done_cnt_o + CNT_W'(1);
      if (timeout_hit) err_timeout_o <= 1'b1;
      wd_cnt <= (state == SEQ_WAIT) ? wd_cnt + WD_W'(1) : '0;
    end
  end

endmodule
